// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen
// Brief    : VGA timing generator. Produces a half-rate pixel enable, x/y
//            pixel counters, visible-area and vertical-blanking flags, a
//            completed-frame counter, and registered hsync/vsync/rgb outputs
//            that lag the presented x/y by one pixel period.
// Revision : 1.0  initial release
// ============================================================================
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rgb_in,
    output logic       pixel_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       endofframe,
    output logic [7:0] frame_count,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] c_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] c_H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] c_V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0] c_HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] c_HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] c_VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] c_VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic       r_tick;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_video_on;
    logic       r_eof;
    logic [7:0] r_frame;
    logic       r_hsync;
    logic       r_vsync;
    logic [7:0] r_rgb;

    logic       w_x_wrap;
    logic       w_y_oor;
    logic       w_frame_done;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_video_next;
    logic       w_eof_next;
    logic       w_hsync_raw;
    logic       w_vsync_raw;

    // Next-count and flag decode; ">=" comparisons also recover upset values
    always_comb begin
        w_x_wrap     = (r_x >= c_H_LAST);
        w_y_oor      = (r_y > c_V_LAST);
        w_frame_done = w_x_wrap && (r_y == c_V_LAST);
        w_x_next     = w_x_wrap ? 10'd0 : r_x + 10'd1;
        if (w_y_oor) begin
            w_y_next = 10'd0;
        end else if (w_x_wrap) begin
            w_y_next = (r_y == c_V_LAST) ? 10'd0 : r_y + 10'd1;
        end else begin
            w_y_next = r_y;
        end
        w_video_next = (w_x_next < c_H_DISP) && (w_y_next < c_V_DISP);
        w_eof_next   = (w_y_next >= c_V_DISP);
        w_hsync_raw  = !((r_x >= c_HS_START) && (r_x < c_HS_END));
        w_vsync_raw  = !((r_y >= c_VS_START) && (r_y < c_VS_END));
    end

    // Pixel enable: toggles every clk, giving one active cycle in two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= ~r_tick;
        end
    end

    // Counters and flags registered from the next x/y so they align with x/y
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x        <= 10'd0;
            r_y        <= 10'd0;
            r_video_on <= 1'b1;
            r_eof      <= 1'b0;
            r_frame    <= 8'd0;
        end else if (r_tick) begin
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_video_on <= w_video_next;
            r_eof      <= w_eof_next;
            if (w_frame_done) begin
                r_frame <= r_frame + 8'd1;
            end
        end
    end

    // Monitor outputs sampled from the currently presented pixel (one pixel lag)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 8'h00;
        end else if (r_tick) begin
            r_hsync <= w_hsync_raw;
            r_vsync <= w_vsync_raw;
            r_rgb   <= r_video_on ? rgb_in : 8'h00;
        end
    end

    assign pixel_tick  = r_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign video_on    = r_video_on;
    assign endofframe  = r_eof;
    assign frame_count = r_frame;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb_out     = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen
// Brief    : Self-checking bench for vga_sync_gen. A reduced-timing instance
//            (12 px x 8 lines) exercises frame-level behaviour quickly; a
//            default-timing instance checks the 800-pixel line and hsync.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_sync_gen;

    logic       clk;
    logic       reset;
    logic [7:0] rgb_in;

    // reduced-timing instance: H 6/2/2/2 (12), V 4/1/2/1 (8)
    logic       s_tick, s_von, s_eof, s_hs, s_vs;
    logic [9:0] s_x, s_y;
    logic [7:0] s_fc, s_rgb;

    // default-timing instance
    logic       d_tick, d_von, d_eof, d_hs, d_vs;
    logic [9:0] d_x, d_y;
    logic [7:0] d_fc, d_rgb;

    int checks = 0;
    int errors = 0;

    vga_sync_gen #(
        .H_DISPLAY(6), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .pixel_tick(s_tick), .x(s_x), .y(s_y), .video_on(s_von),
        .endofframe(s_eof), .frame_count(s_fc), .hsync(s_hs),
        .vsync(s_vs), .rgb_out(s_rgb)
    );

    vga_sync_gen u_dut_def (
        .clk(clk), .reset(reset), .rgb_in(rgb_in),
        .pixel_tick(d_tick), .x(d_x), .y(d_y), .video_on(d_von),
        .endofframe(d_eof), .frame_count(d_fc), .hsync(d_hs),
        .vsync(d_vs), .rgb_out(d_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         c;      // clk edges since reset release
        logic [7:0] rgb;    // rgb_in applied while advancing to c
        logic       tick;
        int         x;
        int         y;
        logic       von;
        logic       eof;
        logic       hs;
        logic       vs;
        logic [7:0] rgbo;
        int         fc;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".tick"}, 32'(s_tick), 0);
        chk({tag, ".x"},    32'(s_x),    0);
        chk({tag, ".y"},    32'(s_y),    0);
        chk({tag, ".von"},  32'(s_von),  1);
        chk({tag, ".eof"},  32'(s_eof),  0);
        chk({tag, ".fc"},   32'(s_fc),   0);
        chk({tag, ".hs"},   32'(s_hs),   1);
        chk({tag, ".vs"},   32'(s_vs),   1);
        chk({tag, ".rgb"},  32'(s_rgb),  0);
        chk({tag, ".dx"},   32'(d_x),    0);
        chk({tag, ".dhs"},  32'(d_hs),   1);
        chk({tag, ".dtick"},32'(d_tick), 0);
    endtask

    initial begin
        int cnt;
        int prev_eof, rises, eof_hi, vs_lo, hs_lo, dhs_lo, first_low_x;
        bit seen_rise;

        //            c   rgb    tk x  y  von eof hs vs rgbo  fc
        tbl[0]  = '{  0, 8'h5A, 0, 0, 0, 1, 0, 1, 1, 8'h00, 0};
        tbl[1]  = '{  1, 8'h5A, 1, 0, 0, 1, 0, 1, 1, 8'h00, 0};
        tbl[2]  = '{  2, 8'h5A, 0, 1, 0, 1, 0, 1, 1, 8'h5A, 0};
        tbl[3]  = '{  3, 8'h5A, 1, 1, 0, 1, 0, 1, 1, 8'h5A, 0};
        tbl[4]  = '{  4, 8'h5A, 0, 2, 0, 1, 0, 1, 1, 8'h5A, 0};
        tbl[5]  = '{ 14, 8'h5A, 0, 7, 0, 0, 0, 1, 1, 8'h00, 0};
        tbl[6]  = '{ 18, 8'h5A, 0, 9, 0, 0, 0, 0, 1, 8'h00, 0};
        tbl[7]  = '{ 20, 8'h5A, 0,10, 0, 0, 0, 0, 1, 8'h00, 0};
        tbl[8]  = '{ 22, 8'h5A, 0,11, 0, 0, 0, 1, 1, 8'h00, 0};
        tbl[9]  = '{ 24, 8'h5A, 0, 0, 1, 1, 0, 1, 1, 8'h00, 0};
        tbl[10] = '{ 26, 8'hC3, 0, 1, 1, 1, 0, 1, 1, 8'hC3, 0};
        tbl[11] = '{ 96, 8'hC3, 0, 0, 4, 0, 1, 1, 1, 8'h00, 0};
        tbl[12] = '{120, 8'hC3, 0, 0, 5, 0, 1, 1, 1, 8'h00, 0};
        tbl[13] = '{122, 8'hC3, 0, 1, 5, 0, 1, 1, 0, 8'h00, 0};
        tbl[14] = '{144, 8'hC3, 0, 0, 6, 0, 1, 1, 0, 8'h00, 0};
        tbl[15] = '{168, 8'hC3, 0, 0, 7, 0, 1, 1, 0, 8'h00, 0};
        tbl[16] = '{170, 8'hC3, 0, 1, 7, 0, 1, 1, 1, 8'h00, 0};
        tbl[17] = '{190, 8'hC3, 0,11, 7, 0, 1, 1, 1, 8'h00, 0};
        tbl[18] = '{192, 8'hC3, 0, 0, 0, 1, 0, 1, 1, 8'h00, 1};
        tbl[19] = '{194, 8'hC3, 0, 1, 0, 1, 0, 1, 1, 8'hC3, 1};

        // power-on reset
        reset  = 1'b1;
        rgb_in = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        chk_reset("por");
        reset = 1'b0;

        // table-driven walk through the first frame and into the second
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            rgb_in = tbl[i].rgb;
            while (cnt < tbl[i].c) begin
                step();
                cnt++;
            end
            chk($sformatf("t%0d.tick", i), 32'(s_tick), 32'(tbl[i].tick));
            chk($sformatf("t%0d.x", i),    32'(s_x),    32'(tbl[i].x));
            chk($sformatf("t%0d.y", i),    32'(s_y),    32'(tbl[i].y));
            chk($sformatf("t%0d.von", i),  32'(s_von),  32'(tbl[i].von));
            chk($sformatf("t%0d.eof", i),  32'(s_eof),  32'(tbl[i].eof));
            chk($sformatf("t%0d.hs", i),   32'(s_hs),   32'(tbl[i].hs));
            chk($sformatf("t%0d.vs", i),   32'(s_vs),   32'(tbl[i].vs));
            chk($sformatf("t%0d.rgb", i),  32'(s_rgb),  32'(tbl[i].rgbo));
            chk($sformatf("t%0d.fc", i),   32'(s_fc),   32'(tbl[i].fc));
        end

        // mid-frame reset: asserted between clock edges, held 3 clk
        repeat (7) step();
        reset = 1'b1;
        #1;
        chk_reset("async");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk_reset("held");
        reset  = 1'b0;
        rgb_in = 8'hFF;

        // 256 reduced frames, with the default-timing line observed on the way
        prev_eof = 0; rises = 0; eof_hi = 0; vs_lo = 0; hs_lo = 0;
        dhs_lo = 0; first_low_x = -1; seen_rise = 0;
        for (int c = 1; c <= 49152; c++) begin
            step();
            if (s_eof && prev_eof == 0) begin
                rises++;
                if (!seen_rise) begin
                    seen_rise = 1;
                    chk("eof_rise_x", 32'(s_x), 0);
                    chk("eof_rise_y", 32'(s_y), 4);
                end
            end
            prev_eof = int'(s_eof);
            if (c <= 192) begin
                if (s_eof) eof_hi++;
                if (!s_vs) vs_lo++;
            end
            if (c <= 23 && !s_hs) hs_lo++;
            if (c <= 1700 && !d_hs) begin
                if (first_low_x < 0) first_low_x = int'(d_x);
                dhs_lo++;
            end
            case (c)
                6:     begin
                           chk("restart_x", 32'(s_x), 3);
                           chk("restart_y", 32'(s_y), 0);
                           chk("restart_fc", 32'(s_fc), 0);
                       end
                191:   chk("fc_before_wrap", 32'(s_fc), 0);
                192:   chk("fc_after_wrap", 32'(s_fc), 1);
                1280:  chk("d_rgb_visible", 32'(d_rgb), 32'hFF);
                1282:  chk("d_rgb_blank", 32'(d_rgb), 0);
                1598:  begin
                           chk("d_x_last", 32'(d_x), 799);
                           chk("d_y_line0", 32'(d_y), 0);
                       end
                1600:  begin
                           chk("d_x_wrap", 32'(d_x), 0);
                           chk("d_y_line1", 32'(d_y), 1);
                       end
                48958: chk("fc_254", 32'(s_fc), 254);
                48960: chk("fc_255", 32'(s_fc), 255);
                default: ;
            endcase
        end
        chk("eof_rises", 32'(rises), 256);
        chk("fc_wrap0", 32'(s_fc), 0);
        chk("end_x", 32'(s_x), 0);
        chk("end_y", 32'(s_y), 0);
        chk("eof_high_clks", 32'(eof_hi), 96);
        chk("vsync_low_clks", 32'(vs_lo), 48);
        chk("hsync_low_clks", 32'(hs_lo), 4);
        chk("d_hsync_low_clks", 32'(dhs_lo), 192);
        chk("d_hsync_first_x", 32'(first_low_x), 657);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch

REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk, in, 1, 50 MHz system clock
- reset, in, 1, asynchronous active-high reset
- rgb_in, in, 8, pixel colour {R[2:0], G[2:0], B[1:0]} from the game graphics mux, for the current x/y
- pixel_tick, out, 1, 25 MHz pixel enable, one clk high in two
- x, out, 10, horizontal pixel count
- y, out, 10, vertical line count
- video_on, out, 1, current x/y inside visible area
- endofframe, out, 1, high while y is in vertical blanking
- frame_count, out, 8, completed-frame counter
- hsync, out, 1, to monitor, active-low
- vsync, out, 1, to monitor, active-low
- rgb_out, out, 8, to monitor DAC

Function
REQ-003 SHALL derive H_TOTAL = sum of H parameters (800) and V_TOTAL = sum of V parameters (525).
REQ-004 pixel_tick SHALL come from a register that toggles on every clk rising edge; all other state SHALL update only on edges where pixel_tick==1.
REQ-005 x SHALL count 0..H_TOTAL-1 and wrap to 0; y SHALL increment only on that x wrap.
REQ-006 y SHALL count 0..V_TOTAL-1 and wrap to 0 when x and y wrap together.
REQ-007 frame_count SHALL increment by one on the y wrap and SHALL wrap 255->0 modulo 2^8.
REQ-008 video_on SHALL be registered and equal (x<H_DISPLAY && y<V_DISPLAY) for the x/y presented in the same cycle.
REQ-009 endofframe SHALL be registered and equal (y>=V_DISPLAY) for the y presented in the same cycle.
REQ-010 Consequences of REQ-009:
- endofframe rises in the same cycle y becomes V_DISPLAY (x=0).
- It falls when y becomes 0.
- It gives exactly one rising edge per frame.
REQ-011 Internal hsync_raw SHALL be low iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
REQ-012 Internal vsync_raw SHALL be low iff V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
REQ-013 rgb_out SHALL register, on each pixel_tick edge, rgb_in when video_on==1, else 8'h00.
REQ-014 hsync and vsync SHALL register hsync_raw/vsync_raw on the same pixel_tick edge as rgb_out; all three monitor outputs therefore lag x/y by exactly one pixel period.
REQ-015 x, y, video_on and endofframe SHALL be driven only from registers (no combinational path from counters to ports).
REQ-016 Counters SHALL use no state beyond 0..H_TOTAL-1 and 0..V_TOTAL-1; an out-of-range value (upset) SHALL wrap to 0 on the next pixel_tick.

Reset
REQ-017 On reset assertion, without waiting for clk, outputs SHALL take these values:
- pixel_tick=0, x=0, y=0
- video_on=1, endofframe=0, frame_count=0
- hsync=1, vsync=1, rgb_out=8'h00
REQ-018 Reset asserted mid-frame SHALL abandon the frame; frame_count SHALL NOT increment for it.
REQ-019 After reset deassertion:
- first clk edge sets pixel_tick=1
- second clk edge advances x 0->1

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- Release reset, run 4 clk -> pixel_tick pattern 1,0,1,0; x steps 0->1->2 every 2 clk.
- Run one line -> x wraps 799->0 and y goes 0->1 together; hsync low for exactly 192 clk, first low when the x=657 cycle is presented.
- Run one frame -> endofframe rises when y=480/x=0 and stays high 45x800x2=72000 clk; vsync low for 2 lines (3200 clk); frame_count 0->1 at y wrap.
- rgb_in=8'hFF constant -> rgb_out=FF one pixel after each visible x/y; 00 for x=640..799 and y>=480.
- Assert reset at y=200/x=300 for 3 clk -> all outputs at REQ-017 values immediately; frame_count unchanged (0); restart from x=0,y=0.
- Run 256 frames -> frame_count wraps 255->0; endofframe shows exactly 256 rising edges.
